// File: rtl/skp_insertion_scheduler_pkg.sv
// Shared TX definitions for the SKP insertion scheduler.
// State encoding and default SKP cadence constants.
package skp_insertion_scheduler_pkg;

  localparam int DEF_SKP_INTERVAL_GEN3  = 370;
  localparam int DEF_SKP_INTERVAL_GEN12 = 1180;
  localparam int DEF_MAX_PENDING        = 2;
  localparam int DEF_CNT_WIDTH          = 11;
  localparam int PEND_WIDTH             = 2;

  typedef enum logic [1:0] {
    ST_IDLE,
    ST_RUN,
    ST_REQ,
    ST_SEND
  } skp_state_e;

  typedef logic [PEND_WIDTH-1:0] skp_pend_t;

endpackage

// File: rtl/skp_insertion_scheduler_counter.sv
// SKP interval counter: selects the interval, restarts on a
// generation change and pulses o_expire on the wrapping tick.
module skp_interval_counter
  import skp_insertion_scheduler_pkg::*;
#(
  parameter int SKP_INTERVAL_GEN3  = DEF_SKP_INTERVAL_GEN3,
  parameter int SKP_INTERVAL_GEN12 = DEF_SKP_INTERVAL_GEN12,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic local_clk,
  input  logic local_rst,
  input  logic i_clr,
  input  logic i_gen,
  input  logic i_tick,
  output logic o_expire
);

  localparam logic [CNT_WIDTH-1:0] LAST_G3 =
    CNT_WIDTH'(SKP_INTERVAL_GEN3 - 1);
  localparam logic [CNT_WIDTH-1:0] LAST_G12 =
    CNT_WIDTH'(SKP_INTERVAL_GEN12 - 1);

  logic                 r_gen;
  logic [CNT_WIDTH-1:0] r_cnt;
  logic [CNT_WIDTH-1:0] w_last;
  logic                 w_gen_chg;
  logic                 w_at_last;

  assign w_last    = i_gen ? LAST_G3 : LAST_G12;
  assign w_gen_chg = i_gen ^ r_gen;
  assign w_at_last = (r_cnt == w_last);

  // A generation change wins over a same-cycle tick.
  assign o_expire = !i_clr && !w_gen_chg &&
                    i_tick && w_at_last;

  always_ff @(posedge local_clk or negedge local_rst) begin
    if (!local_rst) begin
      r_gen <= 1'b0;
      r_cnt <= '0;
    end else begin
      r_gen <= i_gen;
      if (i_clr || w_gen_chg) begin
        r_cnt <= '0;
      end else if (i_tick) begin
        if (w_at_last) begin
          r_cnt <= '0;
        end else begin
          r_cnt <= r_cnt + 1'b1;
        end
      end
    end
  end

endmodule

// File: rtl/skp_insertion_scheduler.sv
// Transmit-side SKP ordered-set scheduler: tracks owed SKP OS
// and requests insertion at legal boundaries.
module skp_insertion_scheduler
  import skp_insertion_scheduler_pkg::*;
#(
  parameter int SKP_INTERVAL_GEN3  = DEF_SKP_INTERVAL_GEN3,
  parameter int SKP_INTERVAL_GEN12 = DEF_SKP_INTERVAL_GEN12,
  parameter int MAX_PENDING        = DEF_MAX_PENDING,
  parameter int CNT_WIDTH          = DEF_CNT_WIDTH
) (
  input  logic                  local_clk,
  input  logic                  local_rst,
  input  logic                  i_ltssm_rst,
  input  logic                  i_higher_gen_en,
  input  logic                  i_tx_active,
  input  logic                  i_tick,
  input  logic                  i_boundary,
  input  logic                  i_pkt_busy,
  input  logic                  i_skp_ack,
  input  logic                  i_skp_done,
  output logic                  o_skp_req,
  output logic                  o_data_stall,
  output logic [PEND_WIDTH-1:0] o_skp_pending,
  output logic                  o_skp_overflow
);

  localparam skp_pend_t PEND_MAX = PEND_WIDTH'(MAX_PENDING);

  skp_state_e r_state;
  skp_state_e w_state_n;
  skp_pend_t  r_pend;
  skp_pend_t  w_pend_n;
  logic       r_req;
  logic       w_req_n;
  logic       r_stall;
  logic       w_stall_n;
  logic       r_ovf;
  logic       w_ovf_n;
  logic       w_cnt_clr;
  logic       w_expire;
  logic       w_inc;
  logic       w_dec;
  logic       w_full;

  // Counter only runs while the link is active and out of IDLE.
  assign w_cnt_clr = i_ltssm_rst || !i_tx_active ||
                     (r_state == ST_IDLE);

  skp_interval_counter #(
    .SKP_INTERVAL_GEN3  (SKP_INTERVAL_GEN3),
    .SKP_INTERVAL_GEN12 (SKP_INTERVAL_GEN12),
    .CNT_WIDTH          (CNT_WIDTH)
  ) u_cnt (
    .local_clk (local_clk),
    .local_rst (local_rst),
    .i_clr     (w_cnt_clr),
    .i_gen     (i_higher_gen_en),
    .i_tick    (i_tick),
    .o_expire  (w_expire)
  );

  assign w_inc  = w_expire;
  assign w_dec  = (r_state == ST_SEND) && i_skp_done;
  assign w_full = (r_pend == PEND_MAX);

  always_comb begin
    w_state_n = r_state;
    w_pend_n  = r_pend;
    w_req_n   = r_req;
    w_stall_n = r_stall;
    w_ovf_n   = r_ovf;
    if (i_ltssm_rst) begin
      w_state_n = ST_IDLE;
      w_pend_n  = '0;
      w_req_n   = 1'b0;
      w_stall_n = 1'b0;
      w_ovf_n   = 1'b0;
    end else if (!i_tx_active) begin
      w_state_n = ST_IDLE;
      w_pend_n  = '0;
      w_req_n   = 1'b0;
      w_stall_n = 1'b0;
    end else begin
      // Simultaneous expire and done cancel out.
      unique case (1'b1)
        w_inc && !w_dec && w_full:
          w_ovf_n = 1'b1;
        w_inc && !w_dec && !w_full:
          w_pend_n = r_pend + 2'd1;
        w_dec && !w_inc:
          w_pend_n = r_pend - 2'd1;
        default: ;
      endcase
      unique case (r_state)
        ST_IDLE: begin
          w_state_n = ST_RUN;
        end
        ST_RUN: begin
          if ((r_pend != '0) && i_boundary &&
              !i_pkt_busy) begin
            w_state_n = ST_REQ;
            w_req_n   = 1'b1;
            w_stall_n = 1'b1;
          end
        end
        ST_REQ: begin
          if (i_skp_ack) begin
            w_state_n = ST_SEND;
            w_req_n   = 1'b0;
          end
        end
        ST_SEND: begin
          if (i_skp_done) begin
            w_state_n = ST_RUN;
            w_stall_n = 1'b0;
          end
        end
        default: begin
          w_state_n = ST_IDLE;
        end
      endcase
    end
  end

  always_ff @(posedge local_clk or negedge local_rst) begin
    if (!local_rst) begin
      r_state <= ST_IDLE;
      r_pend  <= '0;
      r_req   <= 1'b0;
      r_stall <= 1'b0;
      r_ovf   <= 1'b0;
    end else begin
      r_state <= w_state_n;
      r_pend  <= w_pend_n;
      r_req   <= w_req_n;
      r_stall <= w_stall_n;
      r_ovf   <= w_ovf_n;
    end
  end

  assign o_skp_req      = r_req;
  assign o_data_stall   = r_stall;
  assign o_skp_pending  = r_pend;
  assign o_skp_overflow = r_ovf;

endmodule

// File: tb/tb_skp_insertion_scheduler.sv
// Scoreboard bench for skp_insertion_scheduler: every output change
// is matched against a queue of expected {edge, value} events.
module tb_skp_insertion_scheduler;

  logic       clk   = 1'b0;
  logic       rst   = 1'b1;
  logic       ltssm = 1'b0;
  logic       gen   = 1'b1;
  logic       txa   = 1'b0;
  logic       tick  = 1'b0;
  logic       bnd   = 1'b0;
  logic       busy  = 1'b0;
  logic       ack   = 1'b0;
  logic       done  = 1'b0;
  logic       req;
  logic       stall;
  logic       ovf;
  logic [1:0] pend;
  logic [4:0] vec;
  logic [4:0] prev;

  int n_chk  = 0;
  int n_fail = 0;
  int edges  = 0;
  int cur    = 0;
  bit mon_on = 1'b0;

  typedef struct {
    int         edge_no;
    logic [4:0] v;
  } exp_t;

  exp_t q[$];
  exp_t m_e;

  always #5 clk = ~clk;

  skp_insertion_scheduler dut (
    .local_clk       (clk),
    .local_rst       (rst),
    .i_ltssm_rst     (ltssm),
    .i_higher_gen_en (gen),
    .i_tx_active     (txa),
    .i_tick          (tick),
    .i_boundary      (bnd),
    .i_pkt_busy      (busy),
    .i_skp_ack       (ack),
    .i_skp_done      (done),
    .o_skp_req       (req),
    .o_data_stall    (stall),
    .o_skp_pending   (pend),
    .o_skp_overflow  (ovf)
  );

  // {overflow, pending[1:0], stall, req}
  assign vec = {ovf, pend, stall, req};

  task automatic push(input logic [4:0] v);
    exp_t e;
    e.edge_no = cur;
    e.v       = v;
    q.push_back(e);
  endtask

  // Drive one cycle; other inputs set right after a call apply to it.
  task automatic drv(input bit t, input bit a = 1'b0,
                     input bit d = 1'b0);
    @(negedge clk);
    tick = t;
    ack  = a;
    done = d;
    cur  = edges + 1;
  endtask

  always @(posedge clk) begin
    #2;
    edges++;
    if (mon_on && (vec !== prev)) begin
      n_chk++;
      if (q.size() == 0) begin
        n_fail++;
        $display("FAIL unexpected_change edge %0d: got %b, required %b",
                 edges, vec, prev);
      end else begin
        m_e = q.pop_front();
        if ((m_e.edge_no != edges) || (m_e.v !== vec)) begin
          n_fail++;
          $display("FAIL output_event: got %b at edge %0d, required %b at edge %0d",
                   vec, edges, m_e.v, m_e.edge_no);
        end
      end
      prev = vec;
    end
  end

  initial begin
    #1 rst = 1'b0;
    repeat (3) @(negedge clk);
    n_chk++;
    if (vec !== 5'b0) begin
      n_fail++;
      $display("FAIL reset_state: got %b, required 00000", vec);
    end
    rst    = 1'b1;
    prev   = vec;
    mon_on = 1'b1;

    // Gen3 basic cadence
    drv(0); txa = 1'b1; bnd = 1'b1;
    repeat (370) drv(1);
    push(5'b0_01_00);
    drv(0); push(5'b0_01_11);
    drv(0);
    drv(0, 1); push(5'b0_01_10);
    drv(0);
    drv(0, 0, 1); push(5'b0_00_00);

    // Gen1/2: 1179 ticks give nothing, the 1180th expires
    drv(0); gen = 1'b0;
    for (int i = 0; i < 1179; i++) drv(1, i == 500, i == 500);
    drv(0);
    drv(0);
    drv(1); push(5'b0_01_00);
    drv(0); push(5'b0_01_11);
    drv(0, 1); push(5'b0_01_10);
    drv(0, 0, 1); push(5'b0_00_00);

    // Gen3 saturation and overflow under pkt_busy
    drv(0); gen = 1'b1; busy = 1'b1;
    for (int i = 1; i <= 1110; i++) begin
      drv(1);
      if (i == 370)  push(5'b0_01_00);
      if (i == 740)  push(5'b0_10_00);
      if (i == 1110) push(5'b1_10_00);
    end
    drv(0); busy = 1'b0; push(5'b1_10_11);
    drv(0, 1); push(5'b1_10_10);
    drv(0, 0, 1); push(5'b1_01_00);
    drv(0); push(5'b1_01_11);
    drv(0, 1); push(5'b1_01_10);
    drv(0, 0, 1); push(5'b1_00_00);

    // Expire and done in the same cycle
    repeat (370) drv(1);
    push(5'b1_01_00);
    drv(0); push(5'b1_01_11);
    drv(0, 1); push(5'b1_01_10);
    repeat (369) drv(1);
    drv(1, 0, 1); push(5'b1_01_00);
    drv(0); push(5'b1_01_11);
    drv(0, 1); push(5'b1_01_10);

    // tx_active drop during SEND
    drv(0); txa = 1'b0; push(5'b1_00_00);
    drv(0); txa = 1'b1;

    // LTSSM_rst during REQ, ack in the same cycle
    repeat (370) drv(1);
    push(5'b1_01_00);
    drv(0); push(5'b1_01_11);
    drv(0);
    drv(0, 1); ltssm = 1'b1; push(5'b0_00_00);
    drv(0); ltssm = 1'b0;

    // Gen change at count 200 restarts the counter
    repeat (200) drv(1);
    drv(0); gen = 1'b0;
    repeat (1179) drv(1);
    drv(1); push(5'b0_01_00);
    drv(0); push(5'b0_01_11);
    drv(0, 1); push(5'b0_01_10);

    // Asynchronous reset mid-SEND
    @(negedge clk);
    #2 rst = 1'b0;
    cur = edges + 1;
    push(5'b0_00_00);
    #1;
    n_chk++;
    if (vec !== 5'b0) begin
      n_fail++;
      $display("FAIL async_reset: got %b, required 00000", vec);
    end
    repeat (2) @(negedge clk);
    rst = 1'b1;
    repeat (4) drv(0);

    n_chk++;
    if (q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d left, required 0", q.size());
    end
    $display("End of test - %0d assertions evaluated, %0d failures",
             n_chk, n_fail);
    $finish;
  end

endmodule
